// File: rtl/sr_pkg.sv
// Shared definitions for the synchronous SR flip-flop bank: S=R=1 resolution
// modes and the single-bit next-state rule.
package sr_pkg;

    localparam int unsigned SR_HOLD    = 0;
    localparam int unsigned SR_SET_DOM = 1;
    localparam int unsigned SR_RST_DOM = 2;
    localparam int unsigned SR_TOGGLE  = 3;

    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 32;

    // Next value of one SR bit; unknown modes fall back to hold on S=R=1.
    function automatic logic sr_next(input int unsigned mode,
                                     input logic s,
                                     input logic r,
                                     input logic q);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nq = 1'b1;
                    SR_RST_DOM: nq = 1'b0;
                    SR_TOGGLE:  nq = ~q;
                    default:    nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One synchronous SR flip-flop with registered conflict and change pulses.
// The change pulse is named edge_pulse because "edge" is a reserved word.
module sr_ff_cell
    import sr_pkg::*;
#(
    parameter int unsigned MODE     = SR_HOLD,
    parameter logic        INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic conflict,
    output logic edge_pulse
);

    logic q_next;

    assign q_next = sr_next(MODE, s, r, q);

    // Pulses only fire on enabled cycles; reset drops any pending transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q          <= INIT_BIT;
            conflict   <= 1'b0;
            edge_pulse <= 1'b0;
        end else if (en) begin
            q          <= q_next;
            conflict   <= s & r;
            edge_pulse <= q_next ^ q;
        end else begin
            conflict   <= 1'b0;
            edge_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N independent synchronous SR flip-flops with shared clock/enable,
// per-channel conflict/change pulses and a saturating conflict counter.
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int unsigned       N     = 4,
    parameter int unsigned       MODE  = SR_HOLD,
    parameter logic [N-1:0]      INIT  = '0,
    parameter int unsigned       CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             cnt_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     q_n,
    output logic [N-1:0]     conflict,
    output logic [N-1:0]     edge_pulse,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0] conflict_next;
    logic         any_conflict_next;

    for (genvar i = 0; i < int'(N); i++) begin : g_cell
        sr_ff_cell #(
            .MODE     (MODE),
            .INIT_BIT (INIT[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .s          (s[i]),
            .r          (r[i]),
            .q          (q[i]),
            .conflict   (conflict[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

    // Inverse of the flop outputs only, so q_n can never disagree with q.
    assign q_n = ~q;

    // Same condition the cells register into conflict on this edge.
    assign conflict_next     = {N{en}} & s & r;
    assign any_conflict_next = |conflict_next;

    // Saturating counter; a same-edge clear beats the increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (any_conflict_next && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench: five sr_ff_bank variants (all modes, illegal mode, varied
// INIT/CNT_W) share stimulus and are checked against a word-level model.
module tb_sr_ff_bank;

    localparam int ND = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       cnt_clr;

    logic [ND-1:0][3:0] qv, qnv, cfv, edv;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;
    logic [2:0] cnt4;

    always #5 clk = ~clk;

    sr_ff_bank #(.N(4), .MODE(0), .INIT(4'b0000), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qv[0]), .q_n(qnv[0]), .conflict(cfv[0]), .edge_pulse(edv[0]), .conflict_cnt(cnt0));
    sr_ff_bank #(.N(4), .MODE(1), .INIT(4'b1010), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qv[1]), .q_n(qnv[1]), .conflict(cfv[1]), .edge_pulse(edv[1]), .conflict_cnt(cnt1));
    sr_ff_bank #(.N(4), .MODE(2), .INIT(4'b0101), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qv[2]), .q_n(qnv[2]), .conflict(cfv[2]), .edge_pulse(edv[2]), .conflict_cnt(cnt2));
    sr_ff_bank #(.N(4), .MODE(3), .INIT(4'b0000), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qv[3]), .q_n(qnv[3]), .conflict(cfv[3]), .edge_pulse(edv[3]), .conflict_cnt(cnt3));
    sr_ff_bank #(.N(4), .MODE(5), .INIT(4'b0011), .CNT_W(3)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qv[4]), .q_n(qnv[4]), .conflict(cfv[4]), .edge_pulse(edv[4]), .conflict_cnt(cnt4));

    typedef struct {
        logic [ND-1:0][3:0] q;
        logic [ND-1:0][3:0] qn;
        logic [ND-1:0][3:0] cf;
        logic [ND-1:0][3:0] ed;
        logic [ND-1:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int tests  = 0;
    int failed = 0;

    int         m_mode[ND] = '{0, 1, 2, 3, 5};
    logic [3:0] m_init[ND] = '{4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b0011};
    int         m_cmax[ND] = '{255, 255, 3, 255, 7};
    logic [3:0] m_q[ND];
    int         m_cnt[ND];

    // Word-level rule: set-only bits go high, reset-only bits go low, then
    // bits with both requests are resolved for the whole word per mode.
    function automatic logic [3:0] word_next(input int mode, input logic [3:0] q,
                                             input logic [3:0] sv, input logic [3:0] rv);
        logic [3:0] both, nq;
        both = sv & rv;
        nq   = (q | (sv & ~rv)) & ~(rv & ~sv);
        if (mode == 1)      nq = nq | both;
        else if (mode == 2) nq = nq & ~both;
        else if (mode == 3) nq = nq ^ both;
        return nq;
    endfunction

    task automatic step(input logic rst_v, input logic en_v, input logic [3:0] s_v,
                        input logic [3:0] r_v, input logic clr_v);
        exp_t       e;
        logic [3:0] nq, cf;
        rst = rst_v; en = en_v; s = s_v; r = r_v; cnt_clr = clr_v;
        for (int d = 0; d < ND; d++) begin
            if (!rst_v) begin
                nq       = m_init[d];
                cf       = 4'b0000;
                e.ed[d]  = 4'b0000;
                m_cnt[d] = 0;
            end else begin
                nq      = en_v ? word_next(m_mode[d], m_q[d], s_v, r_v) : m_q[d];
                cf      = en_v ? (s_v & r_v) : 4'b0000;
                e.ed[d] = nq ^ m_q[d];
                if (clr_v) m_cnt[d] = 0;
                else if (cf != 4'b0000 && m_cnt[d] < m_cmax[d]) m_cnt[d] = m_cnt[d] + 1;
            end
            m_q[d]   = nq;
            e.q[d]   = nq;
            e.qn[d]  = ~nq;
            e.cf[d]  = cf;
            e.cnt[d] = 8'(m_cnt[d]);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int d, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per negedge.
    initial begin
        exp_t e;
        int   act_cnt[ND];
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act_cnt[0] = int'(cnt0);
                act_cnt[1] = int'(cnt1);
                act_cnt[2] = int'(cnt2);
                act_cnt[3] = int'(cnt3);
                act_cnt[4] = int'(cnt4);
                for (int d = 0; d < ND; d++) begin
                    check("q",            d, int'(qv[d]),  int'(e.q[d]));
                    check("q_n",          d, int'(qnv[d]), int'(e.qn[d]));
                    check("conflict",     d, int'(cfv[d]), int'(e.cf[d]));
                    check("edge_pulse",   d, int'(edv[d]), int'(e.ed[d]));
                    check("conflict_cnt", d, act_cnt[d],   int'(e.cnt[d]));
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_q[d]   = m_init[d];
            m_cnt[d] = 0;
        end
        // reset with requests active
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        // basic set / reset / hold
        step(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        // single conflict cycle, then three in a row
        step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
        repeat (3) step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        // enable gating
        step(1'b1, 1'b1, 4'b0000, 4'hF, 1'b0);
        repeat (5) step(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
        // saturation then clear racing a conflict
        repeat (9) step(1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0);
        step(1'b1, 1'b1, 4'b0110, 4'b0110, 1'b1);
        step(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0);
        // reset mid-operation with a pending clear of all channels
        step(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
        end
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
